gate_sweep_ctrl: RTL and testbench

Self-test sequencer for small combinational logic gates, such as the 2-input XNOR cell.
- Drives every input vector of the gate under test (GUT) in ascending order and waits a programmable settle time per vector.
- Samples the GUT output, compares it against an expected truth table latched at start, and reports a pass flag, per-vector fail mask and fail count.
- Sits beside the GUT in the logic-cell test wrapper, replacing hand-written vector benches.

---
 rtl/gate_sweep_ctrl.sv | 124 ++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer for small combinational gates: walks every input vector,
// lets it settle, and compares the gate output against a latched truth table.
module gate_sweep_ctrl #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2,
    localparam int NV    = 2 ** N_IN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [NV-1:0]     exp_tt,
    output logic [N_IN-1:0]   dut_in,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [NV-1:0]     fail_mask,
    output logic [N_IN:0]     fail_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_FINISH
    } state_t;

    state_t            state;
    logic [N_IN-1:0]   vec;
    logic [3:0]        wait_cnt;
    logic [NV-1:0]     tt;
    logic              mismatch;
    logic              last_vec;
    logic              settled;

    // X/Z on dut_out is not distinguished here; a plain XOR is all synthesis needs.
    assign mismatch = dut_out ^ tt[vec];
    assign last_vec = (vec == N_IN'(NV - 1));
    assign settled  = (wait_cnt == 4'(SETTLE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            vec        <= '0;
            wait_cnt   <= '0;
            tt         <= '0;
            dut_in     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_mask  <= '0;
            fail_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        tt         <= exp_tt;
                        vec        <= '0;
                        dut_in     <= '0;
                        wait_cnt   <= '0;
                        pass       <= 1'b0;
                        fail_mask  <= '0;
                        fail_count <= '0;
                        busy       <= 1'b1;
                        state      <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (abort) begin
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        dut_in <= '0;
                        pass   <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                        if (settled) begin
                            state <= ST_CHECK;
                        end
                    end
                end

                ST_CHECK: begin
                    // A mismatch seen in this cycle is kept even if the sweep aborts now.
                    if (mismatch) begin
                        fail_mask[vec] <= 1'b1;
                        fail_count     <= fail_count + (N_IN + 1)'(1);
                    end
                    if (abort) begin
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        dut_in <= '0;
                        pass   <= 1'b0;
                    end else if (last_vec) begin
                        state <= ST_FINISH;
                        done  <= 1'b1;
                        pass  <= (fail_count == '0) && !mismatch;
                    end else begin
                        vec      <= vec + N_IN'(1);
                        dut_in   <= vec + N_IN'(1);
                        wait_cnt <= '0;
                        state    <= ST_SETTLE;
                    end
                end

                ST_FINISH: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    dut_in <= '0;
                    if (abort) begin
                        pass <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl driving a behavioural 2-input gate model
// (XNOR or stuck-at-0) beside the sequencer.
module tb_gate_sweep_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] exp_tt;
    logic [1:0] dut_in;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;
    logic [2:0] fail_count;

    logic       gut_stuck;
    int         tests;
    int         fails;

    int         done_cyc;
    int         done_cnt;
    logic       busy13;
    logic       busy14;
    logic       post_busy;
    logic [1:0] post_dut;
    logic       pass_c1;
    logic [3:0] mask_c1;

    gate_sweep_ctrl #(
        .N_IN   (2),
        .SETTLE (2)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .exp_tt     (exp_tt),
        .dut_in     (dut_in),
        .dut_out    (dut_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_mask  (fail_mask),
        .fail_count (fail_count)
    );

    assign dut_out = gut_stuck ? 1'b0 : ~(dut_in[0] ^ dut_in[1]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        tests++;
        if (got !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, expected);
        end
    endtask

    // Start is sampled at edge 0; loop iteration cyc observes cycle cyc and
    // drives inputs for the edge that ends it.
    task automatic applyStimulus(input logic [3:0] tt, input int abort_at,
                                 input int restart_a, input int restart_b,
                                 input bit check_vec);
        @(negedge clk);
        start  = 1'b1;
        abort  = 1'b0;
        exp_tt = tt;
        done_cyc  = 0;
        done_cnt  = 0;
        busy13    = 1'bx;
        busy14    = 1'bx;
        post_busy = 1'bx;
        post_dut  = 2'bxx;
        pass_c1   = 1'bx;
        mask_c1   = 4'bxxxx;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (cyc == 1) begin
                pass_c1 = pass;
                mask_c1 = fail_mask;
            end
            if (cyc == 13) busy13 = busy;
            if (cyc == 14) busy14 = busy;
            if (cyc == abort_at + 1) begin
                post_busy = busy;
                post_dut  = dut_in;
            end
            if (check_vec && cyc <= 13)
                checkOutput($sformatf("dut_in c%0d", cyc), 32'(dut_in),
                            (cyc <= 12) ? 32'((cyc - 1) / 3) : 32'd3);
            if (cyc == abort_at) abort = 1'b1;
            if (cyc == restart_a || cyc == restart_b) begin
                start  = 1'b1;
                exp_tt = 4'b0000;
            end
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        exp_tt    = 4'b0000;
        gut_stuck = 1'b0;

        #12;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset pass", 32'(pass), 32'd0);
        checkOutput("reset dut_in", 32'(dut_in), 32'd0);
        checkOutput("reset fail_mask", 32'(fail_mask), 32'd0);
        checkOutput("reset fail_count", 32'(fail_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // start together with abort in IDLE must be ignored
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("idle start+abort busy", 32'(busy), 32'd0);

        // Scenario 1: XNOR against its own table
        applyStimulus(4'b1001, -5, -5, -5, 1'b1);
        checkOutput("s1 done cycle", 32'(done_cyc), 32'd13);
        checkOutput("s1 done count", 32'(done_cnt), 32'd1);
        checkOutput("s1 busy c13", 32'(busy13), 32'd1);
        checkOutput("s1 busy c14", 32'(busy14), 32'd0);
        checkOutput("s1 pass", 32'(pass), 32'd1);
        checkOutput("s1 fail_mask", 32'(fail_mask), 32'd0);
        checkOutput("s1 fail_count", 32'(fail_count), 32'd0);

        // Scenario 4: abort during vector 1 SETTLE, then restart
        applyStimulus(4'b1001, 5, -5, -5, 1'b0);
        checkOutput("s4 busy after abort", 32'(post_busy), 32'd0);
        checkOutput("s4 dut_in after abort", 32'(post_dut), 32'd0);
        checkOutput("s4 done count", 32'(done_cnt), 32'd0);
        checkOutput("s4 pass", 32'(pass), 32'd0);
        checkOutput("s4 fail_mask", 32'(fail_mask), 32'd0);
        applyStimulus(4'b1001, -5, -5, -5, 1'b1);
        checkOutput("s4 restart done cycle", 32'(done_cyc), 32'd13);
        checkOutput("s4 restart pass", 32'(pass), 32'd1);

        // Scenario 2: stuck-at-0 gate
        gut_stuck = 1'b1;
        applyStimulus(4'b1001, -5, -5, -5, 1'b0);
        checkOutput("s2 done cycle", 32'(done_cyc), 32'd13);
        checkOutput("s2 fail_mask", 32'(fail_mask), 32'b1001);
        checkOutput("s2 fail_count", 32'(fail_count), 32'd2);
        checkOutput("s2 pass", 32'(pass), 32'd0);

        // Scenario 3: XNOR checked against an XOR table
        gut_stuck = 1'b0;
        applyStimulus(4'b0110, -5, -5, -5, 1'b0);
        checkOutput("s3 fail_mask", 32'(fail_mask), 32'b1111);
        checkOutput("s3 fail_count", 32'(fail_count), 32'd4);
        checkOutput("s3 pass", 32'(pass), 32'd0);
        checkOutput("s3 done count", 32'(done_cnt), 32'd1);

        // Scenario 5: start re-pulsed while busy, then a fresh sweep with an all-zero table
        applyStimulus(4'b1001, -5, 3, 8, 1'b1);
        checkOutput("s5 done cycle", 32'(done_cyc), 32'd13);
        checkOutput("s5 done count", 32'(done_cnt), 32'd1);
        checkOutput("s5 pass", 32'(pass), 32'd1);
        checkOutput("s5 fail_mask", 32'(fail_mask), 32'd0);
        applyStimulus(4'b0000, -5, -5, -5, 1'b0);
        checkOutput("s5b pass cleared c1", 32'(pass_c1), 32'd0);
        checkOutput("s5b mask c1", 32'(mask_c1), 32'd0);
        checkOutput("s5b fail_mask", 32'(fail_mask), 32'b1001);
        checkOutput("s5b fail_count", 32'(fail_count), 32'd2);
        checkOutput("s5b pass", 32'(pass), 32'd0);

        // Scenario 6: async reset in the CHECK cycle of vector 2
        gut_stuck = 1'b1;
        @(negedge clk);
        start  = 1'b1;
        exp_tt = 4'b1001;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("s6 pre-reset dut_in", 32'(dut_in), 32'd2);
        checkOutput("s6 pre-reset fail_mask", 32'(fail_mask), 32'b0001);
        #2 rst = 1'b1;
        #1;
        checkOutput("s6 rst busy", 32'(busy), 32'd0);
        checkOutput("s6 rst dut_in", 32'(dut_in), 32'd0);
        checkOutput("s6 rst fail_mask", 32'(fail_mask), 32'd0);
        checkOutput("s6 rst fail_count", 32'(fail_count), 32'd0);
        checkOutput("s6 rst done", 32'(done), 32'd0);
        checkOutput("s6 rst pass", 32'(pass), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        gut_stuck = 1'b0;
        applyStimulus(4'b1001, -5, -5, -5, 1'b1);
        checkOutput("s6 after done cycle", 32'(done_cyc), 32'd13);
        checkOutput("s6 after pass", 32'(pass), 32'd1);
        checkOutput("s6 after fail_count", 32'(fail_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
